// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-wide RAM port arbiter between instruction fetch (IF) and
// load/store (MEM). Each 1/2/4-byte access is split into byte cycles; read
// bytes are assembled little-endian and a one-cycle done pulse goes back to
// the requester that won the port.
//
// Optional feature: define MEM_CTRL_STAT_EN to add the stat_if, stat_mem and
// stat_wait event counters as output ports.
//
// Timing summary (grant on the edge that ends IDLE cycle T, N bytes):
//   read : address k presented in cycle T+1+k, data captured one cycle later,
//          DONE in cycle T+N+2
//   write: strobe/address/data k in cycle T+1+k, DONE in cycle T+N+1

module mem_ctrl #(
    parameter int ADDR_WIDTH = 17
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [31:0]           if_addr,
    output logic                  if_done,
    output logic [31:0]           if_inst,
    input  logic                  mem_req,
    input  logic                  mem_we,
    input  logic [1:0]            mem_len,
    input  logic [31:0]           mem_addr,
    input  logic [31:0]           mem_wdata,
    output logic                  mem_done,
    output logic [31:0]           mem_rdata,
    input  logic                  flush,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_wr,
    output logic [7:0]            ram_dout,
    input  logic [7:0]            ram_din
`ifdef MEM_CTRL_STAT_EN
    ,
    output logic [31:0]           stat_if,
    output logic [31:0]           stat_mem,
    output logic [31:0]           stat_wait
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                  state_reg;
    state_t                  state_next;

    // Transaction context latched at grant
    logic                    owner_mem_reg;
    logic [31:0]             base_reg;
    logic [31:0]             wdata_reg;
    logic [2:0]              nbytes_reg;
    logic [2:0]              cnt_reg;

    // RAM port registers
    logic [ADDR_WIDTH-1:0]   ram_addr_reg;
    logic                    ram_wr_reg;
    logic [7:0]              ram_dout_reg;

    // Read assembly and held result registers
    logic [31:0]             asm_reg;
    logic [31:0]             asm_merge;
    logic [31:0]             if_inst_reg;
    logic [31:0]             mem_rdata_reg;

    // Decode helpers
    logic                    grant_mem;
    logic                    grant_if;
    logic                    grant_any;
    logic [31:0]             grant_addr;
    logic [2:0]              grant_nbytes;
    logic                    flush_if;
    logic [2:0]              cnt_inc;
    logic [31:0]             next_addr_full;
    logic                    read_last;
    logic                    write_last;
    logic                    cap_en;
    logic [1:0]              cap_lane;
    logic [7:0]              wbyte [4];

    // MEM has fixed priority; a flush in the same IDLE cycle blocks an IF grant
    assign grant_mem    = (state_reg == ST_IDLE) && mem_req;
    assign grant_if     = (state_reg == ST_IDLE) && !mem_req && if_req && !flush;
    assign grant_any    = grant_mem || grant_if;
    assign grant_addr   = grant_mem ? mem_addr : if_addr;
    // mem_len is bytes-1, with the unused code 2 treated as a full word
    assign grant_nbytes = !grant_mem        ? 3'd4 :
                          (mem_len == 2'd0) ? 3'd1 :
                          (mem_len == 2'd1) ? 3'd2 : 3'd4;

    // Flush only aborts a fetch; loads/stores always run to completion
    assign flush_if = flush && !owner_mem_reg &&
                      ((state_reg == ST_READ) || (state_reg == ST_DONE));

    assign cnt_inc        = cnt_reg + 3'd1;
    assign next_addr_full = base_reg + {29'd0, cnt_inc};
    assign read_last      = (state_reg == ST_READ) && (cnt_reg == nbytes_reg);
    assign write_last     = (state_reg == ST_WRITE) && (cnt_inc == nbytes_reg);

    // In READ cycle c (c >= 1) ram_din carries byte c-1
    assign cap_en   = (state_reg == ST_READ) && (cnt_reg != 3'd0);
    assign cap_lane = cnt_reg[1:0] - 2'd1;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi = gi + 1) begin : g_lane
            assign wbyte[gi] = wdata_reg[8*gi +: 8];
            assign asm_merge[8*gi +: 8] = (cap_en && (cap_lane == 2'(gi))) ?
                                          ram_din : asm_reg[8*gi +: 8];
        end
        if (ADDR_WIDTH < 32) begin : g_addr_trunc
            // Bits above the RAM width wrap away by design
            logic addr_hi_unused;
            assign addr_hi_unused = ^next_addr_full[31:ADDR_WIDTH];
        end
    endgenerate

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (grant_mem) begin
                    state_next = mem_we ? ST_WRITE : ST_READ;
                end else if (grant_if) begin
                    state_next = ST_READ;
                end
            end
            ST_READ: begin
                if (flush_if) begin
                    state_next = ST_IDLE;
                end else if (read_last) begin
                    state_next = ST_DONE;
                end
            end
            ST_WRITE: begin
                if (write_last) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Latch owner, base, length and write data at grant
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_mem_reg <= 1'b0;
            base_reg      <= 32'd0;
            wdata_reg     <= 32'd0;
            nbytes_reg    <= 3'd0;
        end else if (grant_any) begin
            owner_mem_reg <= grant_mem;
            base_reg      <= grant_addr;
            wdata_reg     <= mem_wdata;
            nbytes_reg    <= grant_nbytes;
        end
    end

    // Byte-cycle counter within READ/WRITE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg <= 3'd0;
        end else if (grant_any) begin
            cnt_reg <= 3'd0;
        end else if ((state_reg == ST_READ) || (state_reg == ST_WRITE)) begin
            cnt_reg <= cnt_inc;
        end
    end

    // Drive the RAM port one byte per cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ram_addr_reg <= '0;
            ram_wr_reg   <= 1'b0;
            ram_dout_reg <= 8'd0;
        end else if (grant_any) begin
            ram_addr_reg <= grant_addr[ADDR_WIDTH-1:0];
            ram_wr_reg   <= grant_mem && mem_we;
            ram_dout_reg <= (grant_mem && mem_we) ? mem_wdata[7:0] : 8'd0;
        end else if (state_reg == ST_WRITE) begin
            if (write_last) begin
                ram_wr_reg <= 1'b0;
            end else begin
                ram_addr_reg <= next_addr_full[ADDR_WIDTH-1:0];
                ram_dout_reg <= wbyte[cnt_inc[1:0]];
            end
        end else if ((state_reg == ST_READ) && (cnt_inc < nbytes_reg)) begin
            ram_addr_reg <= next_addr_full[ADDR_WIDTH-1:0];
        end
    end

    // Assemble read bytes; cleared at grant so short loads zero-extend
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            asm_reg <= 32'd0;
        end else if (grant_any) begin
            asm_reg <= 32'd0;
        end else if (state_reg == ST_READ) begin
            asm_reg <= asm_merge;
        end
    end

    // Hold load data from the MEM done cycle until the next MEM done
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_rdata_reg <= 32'd0;
        end else if (read_last && owner_mem_reg) begin
            mem_rdata_reg <= asm_merge;
        end
    end

    // Commit the fetched word only when its done pulse survives a flush
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_inst_reg <= 32'd0;
        end else if (if_done) begin
            if_inst_reg <= asm_reg;
        end
    end

    assign if_done   = (state_reg == ST_DONE) && !owner_mem_reg && !flush;
    assign mem_done  = (state_reg == ST_DONE) && owner_mem_reg;
    assign if_inst   = if_done ? asm_reg : if_inst_reg;
    assign mem_rdata = mem_rdata_reg;
    assign busy      = (state_reg != ST_IDLE);
    assign ram_addr  = ram_addr_reg;
    assign ram_wr    = ram_wr_reg;
    assign ram_dout  = ram_dout_reg;

`ifdef MEM_CTRL_STAT_EN
    logic [31:0] stat_if_reg;
    logic [31:0] stat_mem_reg;
    logic [31:0] stat_wait_reg;
    logic        fetch_waiting;

    // IF is waiting when MEM holds the port or is about to win it
    assign fetch_waiting = if_req &&
                           (((state_reg != ST_IDLE) && owner_mem_reg) ||
                            ((state_reg == ST_IDLE) && mem_req));

    // Free-running event counters, wrapping at 2^32
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_if_reg   <= 32'd0;
            stat_mem_reg  <= 32'd0;
            stat_wait_reg <= 32'd0;
        end else begin
            if (if_done) begin
                stat_if_reg <= stat_if_reg + 32'd1;
            end
            if (mem_done) begin
                stat_mem_reg <= stat_mem_reg + 32'd1;
            end
            if (fetch_waiting) begin
                stat_wait_reg <= stat_wait_reg + 32'd1;
            end
        end
    end

    assign stat_if   = stat_if_reg;
    assign stat_mem  = stat_mem_reg;
    assign stat_wait = stat_wait_reg;
`endif

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed scenarios for mem_ctrl with a transaction-level
// reference model checked on every negative clock edge, plus hand-computed
// literal expectations at the interesting cycles of each scenario.

module tb_mem_ctrl;

    localparam int AW    = 17;
    localparam int RAMSZ = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          if_req = 1'b0;
    logic [31:0]   if_addr = 32'd0;
    logic          if_done;
    logic [31:0]   if_inst;
    logic          mem_req = 1'b0;
    logic          mem_we = 1'b0;
    logic [1:0]    mem_len = 2'd0;
    logic [31:0]   mem_addr = 32'd0;
    logic [31:0]   mem_wdata = 32'd0;
    logic          mem_done;
    logic [31:0]   mem_rdata;
    logic          flush = 1'b0;
    logic          busy;
    logic [AW-1:0] ram_addr;
    logic          ram_wr;
    logic [7:0]    ram_dout;
    logic [7:0]    ram_din = 8'd0;
`ifdef MEM_CTRL_STAT_EN
    logic [31:0]   stat_if;
    logic [31:0]   stat_mem;
    logic [31:0]   stat_wait;
`endif

    int vec_cnt = 0;
    int err_cnt = 0;
    int cyc     = 0;

    mem_ctrl #(.ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_done   (if_done),
        .if_inst   (if_inst),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_len   (mem_len),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_done  (mem_done),
        .mem_rdata (mem_rdata),
        .flush     (flush),
        .busy      (busy),
        .ram_addr  (ram_addr),
        .ram_wr    (ram_wr),
        .ram_dout  (ram_dout),
        .ram_din   (ram_din)
`ifdef MEM_CTRL_STAT_EN
        ,
        .stat_if   (stat_if),
        .stat_mem  (stat_mem),
        .stat_wait (stat_wait)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Power-on RAM contents
    function automatic logic [7:0] init_byte(input logic [AW-1:0] a);
        case (a)
            17'h00100: init_byte = 8'h13;
            17'h00101: init_byte = 8'h05;
            17'h00102: init_byte = 8'h00;
            17'h00103: init_byte = 8'h00;
            17'h00010: init_byte = 8'h8F;
            default:   init_byte = a[7:0] ^ 8'h5A;
        endcase
    endfunction

    // Bench RAM: synchronous, read data one cycle after the address
    bit [7:0] ram_data [RAMSZ];
    bit       ram_vld  [RAMSZ];

    always @(posedge clk) begin
        if (ram_wr) begin
            ram_data[ram_addr] <= ram_dout;
            ram_vld[ram_addr]  <= 1'b1;
        end
        ram_din <= ram_vld[ram_addr] ? ram_data[ram_addr] : init_byte(ram_addr);
    end

    // Reference model state: one transaction at a time, timed from its grant
    bit [7:0]    m_data [RAMSZ];
    bit          m_vld  [RAMSZ];
    bit          m_act = 1'b0;
    bit          m_ismem;
    bit          m_we;
    int          m_t;
    int          m_n;
    logic [31:0] m_base;
    logic [31:0] m_wdata;
    logic [31:0] m_word;
    logic [31:0] m_if_inst = 32'd0;
    logic [31:0] m_rdata   = 32'd0;

    function automatic logic [7:0] m_rd(input logic [AW-1:0] a);
        m_rd = m_vld[a] ? m_data[a] : init_byte(a);
    endfunction

    always @(negedge clk) begin : model_chk
        logic          e_busy, e_wr, e_ifd, e_memd, e_chk_addr, end_now;
        logic [AW-1:0] e_addr;
        logic [7:0]    e_dout;
        logic [AW-1:0] a;
        int            k;
        if (!rst) begin
            m_act     = 1'b0;
            m_if_inst = 32'd0;
            m_rdata   = 32'd0;
            chk("rst_busy", busy, 0);
            chk("rst_ram_wr", ram_wr, 0);
            chk("rst_ram_addr", ram_addr, 0);
            chk("rst_ram_dout", ram_dout, 0);
            chk("rst_if_done", if_done, 0);
            chk("rst_mem_done", mem_done, 0);
            chk("rst_if_inst", if_inst, 0);
            chk("rst_mem_rdata", mem_rdata, 0);
        end else begin
            e_busy = 1'b0; e_wr = 1'b0; e_ifd = 1'b0; e_memd = 1'b0;
            e_chk_addr = 1'b0; end_now = 1'b0; e_addr = '0; e_dout = 8'd0;
            if (m_act) begin
                e_busy = 1'b1;
                k = cyc - m_t - 1;
                if (k < m_n) begin
                    e_chk_addr = 1'b1;
                    e_addr = AW'(m_base + 32'(k));
                end
                if (m_we) begin
                    if (k < m_n) begin
                        e_wr   = 1'b1;
                        e_dout = m_wdata[8*k +: 8];
                        m_data[e_addr] = e_dout;
                        m_vld[e_addr]  = 1'b1;
                    end else begin
                        e_memd  = 1'b1;
                        end_now = 1'b1;
                    end
                end else if (!m_ismem && flush) begin
                    end_now = 1'b1;
                end else if (k == m_n + 1) begin
                    end_now = 1'b1;
                    if (m_ismem) begin
                        e_memd  = 1'b1;
                        m_rdata = m_word;
                    end else begin
                        e_ifd     = 1'b1;
                        m_if_inst = m_word;
                    end
                end
            end else begin
                if (mem_req) begin
                    m_act = 1'b1; m_ismem = 1'b1; m_we = mem_we;
                    m_n = (mem_len == 2'd0) ? 1 : (mem_len == 2'd1) ? 2 : 4;
                    m_base = mem_addr; m_wdata = mem_wdata;
                end else if (if_req && !flush) begin
                    m_act = 1'b1; m_ismem = 1'b0; m_we = 1'b0; m_n = 4;
                    m_base = if_addr; m_wdata = 32'd0;
                end
                if (m_act) begin
                    m_t = cyc;
                    m_word = 32'd0;
                    for (int b = 0; b < m_n; b++) begin
                        a = AW'(m_base + 32'(b));
                        m_word[8*b +: 8] = m_rd(a);
                    end
                end
            end
            chk("busy", busy, e_busy);
            chk("ram_wr", ram_wr, e_wr);
            chk("if_done", if_done, e_ifd);
            chk("mem_done", mem_done, e_memd);
            chk("if_inst", if_inst, m_if_inst);
            chk("mem_rdata", mem_rdata, m_rdata);
            if (e_chk_addr) chk("ram_addr", ram_addr, e_addr);
            if (e_wr) chk("ram_dout", ram_dout, e_dout);
            if (end_now) begin
                m_act = 1'b0;
                $display("txn %s %s base=%h n=%0d data=%h end_cycle=%0d",
                         m_ismem ? "MEM" : "IF ", m_we ? "wr" : "rd",
                         m_base, m_n, m_we ? m_wdata : m_word, cyc);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] s2_bytes [4];

    initial begin
        s2_bytes = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        repeat (3) step();
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_ram_addr", ram_addr, 0);
        rst = 1'b1;
        step();

        // Both request together: MEM byte load wins, IF follows
        step();
        if_req = 1'b1; if_addr = 32'h104;
        mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'd0; mem_addr = 32'h10;
        for (int rc = 1; rc <= 11; rc++) begin
            step();
            if (rc == 4) mem_req = 1'b0;
            if (rc == 11) if_req = 1'b0;
            #1;
            if (rc == 1) chk("s3_ram_addr", ram_addr, 32'h10);
            if (rc == 3) begin
                chk("s3_mem_done", mem_done, 1);
                chk("s3_mem_rdata", mem_rdata, 32'h0000008F);
            end
            if (rc == 9) chk("s3_if_done_early", if_done, 0);
            if (rc == 10) begin
                chk("s3_if_done", if_done, 1);
                chk("s3_if_inst", if_inst, 32'h5D5C5F5E);
            end
        end
`ifdef MEM_CTRL_STAT_EN
        chk("s3_stat_if", stat_if, 1);
        chk("s3_stat_mem", stat_mem, 1);
        chk("s3_stat_wait", stat_wait, 4);
`endif

        // Plain fetch
        step();
        if_req = 1'b1; if_addr = 32'h100;
        for (int rc = 1; rc <= 7; rc++) begin
            step();
            if (rc == 7) if_req = 1'b0;
            #1;
            if (rc <= 4) chk("s1_ram_addr", ram_addr, 32'h100 + 32'(rc - 1));
            if (rc == 5) chk("s1_if_done_early", if_done, 0);
            if (rc == 6) begin
                chk("s1_if_done", if_done, 1);
                chk("s1_if_inst", if_inst, 32'h00000513);
            end
        end

        // Word store
        step();
        mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'd3;
        mem_addr = 32'h200; mem_wdata = 32'hDEADBEEF;
        for (int rc = 1; rc <= 6; rc++) begin
            step();
            if (rc == 6) mem_req = 1'b0;
            #1;
            if (rc <= 4) begin
                chk("s2_ram_wr", ram_wr, 1);
                chk("s2_ram_addr", ram_addr, 32'h200 + 32'(rc - 1));
                chk("s2_ram_dout", ram_dout, s2_bytes[rc-1]);
            end
            if (rc == 5) begin
                chk("s2_mem_done", mem_done, 1);
                chk("s2_ram_wr_done", ram_wr, 0);
            end
        end

        // Half load of the stored word, zero-extended
        step();
        mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'd1; mem_addr = 32'h200;
        for (int rc = 1; rc <= 5; rc++) begin
            step();
            if (rc == 5) mem_req = 1'b0;
            #1;
            if (rc == 4) begin
                chk("s2b_mem_done", mem_done, 1);
                chk("s2b_mem_rdata", mem_rdata, 32'h0000BEEF);
            end
        end

        // Fetch aborted by flush in READ, then a new fetch
        step();
        if_req = 1'b1; if_addr = 32'h100;
        for (int rc = 1; rc <= 11; rc++) begin
            step();
            if (rc == 3) flush = 1'b1;
            if (rc == 4) begin flush = 1'b0; if_addr = 32'h108; end
            if (rc == 11) if_req = 1'b0;
            #1;
            if (rc == 3) chk("s4_if_done_flush", if_done, 0);
            if (rc == 4) begin
                chk("s4_busy_idle", busy, 0);
                chk("s4_if_inst_kept", if_inst, 32'h00000513);
            end
            if (rc == 10) begin
                chk("s4_if_done", if_done, 1);
                chk("s4_if_inst", if_inst, 32'h51505352);
            end
        end

        // Flush blocks an IDLE grant; flush in DONE suppresses if_done
        step();
        if_req = 1'b1; flush = 1'b1; if_addr = 32'h10C;
        for (int rc = 1; rc <= 8; rc++) begin
            step();
            if (rc == 1) flush = 1'b0;
            if (rc == 7) flush = 1'b1;
            if (rc == 8) begin flush = 1'b0; if_req = 1'b0; end
            #1;
            if (rc == 1) chk("s4b_no_grant", busy, 0);
            if (rc == 7) begin
                chk("s4b_busy_done", busy, 1);
                chk("s4b_if_done_flush", if_done, 0);
                chk("s4b_if_inst_kept", if_inst, 32'h51505352);
            end
            if (rc == 8) chk("s4b_busy_after", busy, 0);
        end

        // Half store across the RAM top, then a len=2 (word) load across it
        step();
        mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'd1;
        mem_addr = 32'h0001FFFF; mem_wdata = 32'h00001234;
        for (int rc = 1; rc <= 4; rc++) begin
            step();
            if (rc == 4) mem_req = 1'b0;
            #1;
            if (rc == 1) begin
                chk("s5_addr0", ram_addr, 32'h1FFFF);
                chk("s5_dout0", ram_dout, 32'h34);
            end
            if (rc == 2) begin
                chk("s5_addr1", ram_addr, 32'h00000);
                chk("s5_dout1", ram_dout, 32'h12);
            end
            if (rc == 3) chk("s5_mem_done", mem_done, 1);
        end
        chk("s5_ram_top", ram_data[17'h1FFFF], 32'h34);
        chk("s5_ram_bot", ram_data[17'h00000], 32'h12);
        step();
        mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'd2; mem_addr = 32'h0001FFFE;
        for (int rc = 1; rc <= 7; rc++) begin
            step();
            if (rc == 7) mem_req = 1'b0;
            #1;
            if (rc == 6) begin
                chk("s5_load_done", mem_done, 1);
                chk("s5_load_rdata", mem_rdata, 32'h5B1234A4);
            end
        end

        // Reset in the middle of a word store
        step();
        mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'd3;
        mem_addr = 32'h300; mem_wdata = 32'hCAFEF00D;
        step();
        #1;
        chk("s6_ram_wr_before", ram_wr, 1);
        step();
        rst = 1'b0; mem_req = 1'b0;
        #1;
        chk("s6_ram_wr_reset", ram_wr, 0);
        chk("s6_busy_reset", busy, 0);
        chk("s6_mem_done_reset", mem_done, 0);
        step();
        rst = 1'b1;
        repeat (4) step();
        step();
        mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'd3; mem_addr = 32'h300;
        for (int rc = 1; rc <= 7; rc++) begin
            step();
            if (rc == 7) mem_req = 1'b0;
            #1;
            if (rc == 6) chk("s6_partial_rdata", mem_rdata, 32'h59585B0D);
        end

        repeat (3) step();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
